// File: rtl/fluid_regs_pkg.sv
// ============================================================================
// Module      : fluid_regs_pkg
// Description : Address map, FLAGS bit positions and FSM states shared by the
//               fluid register responder and its sub-modules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fluid_regs_pkg;

  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_SCRATCH    = 7'h01;
  localparam logic [6:0] ADDR_FLAGS      = 7'h02;
  localparam logic [6:0] ADDR_EVENT      = 7'h03;
  localparam logic [6:0] ADDR_EVENT_MASK = 7'h04;
  localparam logic [6:0] ADDR_WDOG_KICK  = 7'h05;
  localparam logic [6:0] ADDR_CTRL_BASE  = 7'h10;
  localparam logic [6:0] ADDR_STAT_BASE  = 7'h20;

  localparam int FLAGS_ACCESS_ERR   = 0;
  localparam int FLAGS_WDOG_EXPIRED = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/fluid_event_sticky.sv
// ============================================================================
// Module      : fluid_event_sticky
// Description : 16-bit sticky event register (set wins over write-1-to-clear)
//               with an interrupt mask and a registered level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fluid_event_sticky (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_event_pulse,
  input  logic [15:0] i_event_clr,
  input  logic        i_mask_we,
  input  logic [15:0] i_mask_wdata,
  output logic [15:0] o_event,
  output logic [15:0] o_mask,
  output logic        o_irq
);

  logic [15:0] r_event;
  logic [15:0] r_mask;
  logic        r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_event <= (r_event & ~i_event_clr) | i_event_pulse;
      if (i_mask_we) begin
        r_mask <= i_mask_wdata;
      end
      // Built from the current register values, so irq trails an event by a cycle.
      r_irq <= |(r_event & r_mask);
    end
  end

  assign o_event = r_event;
  assign o_mask  = r_mask;
  assign o_irq   = r_irq;

endmodule

`default_nettype wire

// File: rtl/fluid_avalon_reg_responder.sv
// ============================================================================
// Module      : fluid_avalon_reg_responder
// Description : Avalon-MM register slave (7-bit word address, 16-bit data,
//               waitrequest) for the fluid board: ID, scratch, flags, sticky
//               events with mask/irq, control outputs and status inputs.
//               Optional watchdog enabled by defining FLUID_REGS_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fluid_avalon_reg_responder
  import fluid_regs_pkg::*;
#(
  parameter logic [15:0] ID_VALUE    = 16'hF1D0,
  parameter int          NUM_CTRL    = 16,
  parameter int          NUM_STAT    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] CTRL_RESET  = 16'h0000,
  parameter logic [31:0] WDOG_CYCLES = 32'd50_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [15:0]             avs_writedata,
  output logic                    avs_waitrequest,
  output logic [15:0]             avs_readdata,
  input  logic [15:0]             event_pulse,
  input  logic [16*NUM_STAT-1:0]  stat_in,
  output logic [16*NUM_CTRL-1:0]  ctrl_out,
  output logic                    irq,
  output logic                    wdog_expired
);

  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  fsm_state_t  r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_waitreq;
  logic [15:0] r_rdata;
  logic [15:0] r_scratch;
  logic        r_access_err;
  logic [15:0] r_ctrl [NUM_CTRL];

  logic [15:0] w_event;
  logic [15:0] w_mask;
  logic [15:0] w_rdata;
  logic        w_addr_ok;
  logic        w_addr_ro;
  logic        w_req;
  logic        w_commit;
  logic        w_err;
  logic        w_wr_ok;
  logic        w_kick;
  logic        w_wdog_fire;
  logic        w_wdog_expired;

  // Address decode and read mux; unmapped addresses read 0 and flag an error.
  always_comb begin
    w_rdata   = '0;
    w_addr_ok = 1'b0;
    w_addr_ro = 1'b0;
    case (avs_address)
      ADDR_ID:         begin w_rdata = ID_VALUE;  w_addr_ok = 1'b1; w_addr_ro = 1'b1; end
      ADDR_SCRATCH:    begin w_rdata = r_scratch; w_addr_ok = 1'b1; end
      ADDR_FLAGS: begin
        w_rdata[FLAGS_ACCESS_ERR]   = r_access_err;
        w_rdata[FLAGS_WDOG_EXPIRED] = w_wdog_expired;
        w_addr_ok = 1'b1;
      end
      ADDR_EVENT:      begin w_rdata = w_event;   w_addr_ok = 1'b1; end
      ADDR_EVENT_MASK: begin w_rdata = w_mask;    w_addr_ok = 1'b1; end
      ADDR_WDOG_KICK:  begin w_addr_ok = 1'b1; end
      default: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (avs_address == ADDR_CTRL_BASE + 7'(i)) begin
            w_rdata   = r_ctrl[i];
            w_addr_ok = 1'b1;
          end
        end
        for (int i = 0; i < NUM_STAT; i++) begin
          if (avs_address == ADDR_STAT_BASE + 7'(i)) begin
            w_rdata   = stat_in[16*i +: 16];
            w_addr_ok = 1'b1;
            w_addr_ro = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_req    = avs_read | avs_write;
  assign w_commit = (r_state == DONE) && w_req;
  assign w_err    = w_commit && (!w_addr_ok || (avs_write && (w_addr_ro || avs_read)));
  assign w_wr_ok  = w_commit && avs_write && w_addr_ok && !w_addr_ro;
  assign w_kick   = w_wr_ok && (avs_address == ADDR_WDOG_KICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_waitreq  <= 1'b1;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wait_cnt <= c_wait_load;
            if (WAIT_CYCLES == 0) begin
              r_state   <= DONE;
              r_waitreq <= 1'b0;
              r_rdata   <= w_rdata;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            if (r_wait_cnt == 4'd1) begin
              r_state   <= DONE;
              r_waitreq <= 1'b0;
              r_rdata   <= w_rdata;
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_waitreq <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_waitreq <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch    <= '0;
      r_access_err <= 1'b0;
      for (int i = 0; i < NUM_CTRL; i++) begin
        r_ctrl[i] <= CTRL_RESET;
      end
    end else begin
      if (w_wr_ok && avs_address == ADDR_SCRATCH) begin
        r_scratch <= avs_writedata;
      end
      if (w_err) begin
        r_access_err <= 1'b1;
      end else if (w_wr_ok && avs_address == ADDR_FLAGS && avs_writedata[FLAGS_ACCESS_ERR]) begin
        r_access_err <= 1'b0;
      end
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (w_wdog_fire) begin
          r_ctrl[i] <= CTRL_RESET;
        end else if (w_wr_ok && !w_wdog_expired && avs_address == ADDR_CTRL_BASE + 7'(i)) begin
          r_ctrl[i] <= avs_writedata;
        end
      end
    end
  end

`ifdef FLUID_REGS_WDOG_EN
  logic [31:0] r_wdog_cnt;
  logic        r_wdog_expired;

  // Counter parks at its terminal value; expiry fires once on arrival.
  assign w_wdog_fire    = !w_kick && !r_wdog_expired && (r_wdog_cnt == WDOG_CYCLES - 32'd1);
  assign w_wdog_expired = r_wdog_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog_cnt     <= '0;
      r_wdog_expired <= 1'b0;
    end else if (w_kick) begin
      r_wdog_cnt     <= '0;
      r_wdog_expired <= 1'b0;
    end else if (r_wdog_cnt == WDOG_CYCLES - 32'd1) begin
      r_wdog_expired <= 1'b1;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused       = ^{w_kick, WDOG_CYCLES};
  assign w_wdog_fire    = 1'b0;
  assign w_wdog_expired = 1'b0;
`endif

  fluid_event_sticky u_event_sticky (
    .clk           (clk),
    .rst_n         (reset_n),
    .i_event_pulse (event_pulse),
    .i_event_clr   ((w_wr_ok && avs_address == ADDR_EVENT) ? avs_writedata : 16'h0000),
    .i_mask_we     (w_wr_ok && avs_address == ADDR_EVENT_MASK),
    .i_mask_wdata  (avs_writedata),
    .o_event       (w_event),
    .o_mask        (w_mask),
    .o_irq         (irq)
  );

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl_out
    assign ctrl_out[16*i +: 16] = r_ctrl[i];
  end

  assign avs_waitrequest = r_waitreq;
  assign avs_readdata    = r_rdata;
  assign wdog_expired    = w_wdog_expired;

endmodule

`default_nettype wire
